bpm_window_averager: RTL and testbench

- Parametrised beat-rate meter. Turns the raw pulse-sensor beat level into a moving-average BPM value.
- Counts qualified beats over a fixed window of sclk ticks and keeps the last DEPTH window counts in a circular history. Outputs scaled, saturated BPM for the BCD/seven-segment display path.
- Adds input sync, refractory filtering, a valid flag, and no-signal/saturation flags on top of the fixed 3-window scheme.

---
 rtl/bpm_window_averager.sv | 176 +++++++++++++++++
 tb/tb_bpm_window_averager.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bpm_window_averager.sv
// Beat-rate meter: synchronizes the raw pulse-sensor level, filters beats
// with a refractory gap, counts beats per fixed window of sclk ticks, and
// reports a moving-average BPM over the last DEPTH windows with status flags.
module bpm_window_averager #(
    parameter int WIN_TICKS = 5000,
    parameter int DEPTH     = 4,
    parameter int SCALE     = 4,
    parameter int MIN_GAP   = 250,
    parameter int CW        = 8,
    parameter int BPM_W     = 10
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             clr,
    input  logic             pulse_in,
    output logic             beat,
    output logic             window_done,
    output logic [BPM_W-1:0] bpm,
    output logic             bpm_valid,
    output logic             no_signal,
    output logic             sat
);

    localparam int LOG = $clog2(DEPTH);
    localparam int SW  = CW + LOG;
    localparam int TW  = $clog2(WIN_TICKS);
    localparam int RW  = $clog2(MIN_GAP + 1);
    localparam int FW  = $clog2(DEPTH + 1);
    localparam int PW  = SW + 32;

    localparam logic [TW-1:0] TICK_LAST = TW'(WIN_TICKS - 1);
    localparam logic [RW-1:0] GAP_LOAD  = RW'(MIN_GAP - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [PW-1:0] SCALE_W   = PW'(SCALE);
    localparam logic [PW-1:0] BPM_MAX_W = {{(PW-BPM_W){1'b0}}, {BPM_W{1'b1}}};

    logic           sync1;
    logic           sync2;
    logic           sync3;
    logic [RW-1:0]  refr;
    logic [TW-1:0]  tick;
    logic [CW-1:0]  win_cnt;
    logic [CW-1:0]  hist [DEPTH];
    logic [LOG-1:0] wr_ptr;
    logic [SW-1:0]  sum;
    logic [FW-1:0]  fill;

    logic             rise;
    logic             accept;
    logic             terminal;
    logic             cnt_full;
    logic [CW-1:0]    closing;
    logic [SW-1:0]    new_sum;
    logic [FW-1:0]    fill_next;
    logic [PW-1:0]    product;
    logic [PW-1:0]    scaled;
    logic             bpm_clip;
    logic [BPM_W-1:0] bpm_next;

    // Edge detect, window close arithmetic and the scaled/clipped average
    always_comb begin
        rise      = sync2 & ~sync3;
        accept    = rise && (refr == '0);
        terminal  = (tick == TICK_LAST);
        cnt_full  = (win_cnt == CNT_MAX);
        closing   = (beat && !cnt_full) ? win_cnt + 1'b1 : win_cnt;
        new_sum   = sum + SW'(closing) - SW'(hist[wr_ptr]);
        fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
        product   = PW'(new_sum) * SCALE_W;
        scaled    = product >> LOG;
        bpm_clip  = (scaled > BPM_MAX_W);
        bpm_next  = bpm_clip ? {BPM_W{1'b1}} : scaled[BPM_W-1:0];
    end

    // Synchronizer, refractory counter and the registered beat strobe
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            refr  <= '0;
            beat  <= 1'b0;
        end else if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            refr  <= '0;
            beat  <= 1'b0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
            sync3 <= sync2;
            if (accept) begin
                beat <= 1'b1;
                refr <= GAP_LOAD;
            end else begin
                beat <= 1'b0;
                refr <= (refr == '0) ? refr : refr - 1'b1;
            end
        end
    end

    // Window tick counter and saturating per-window beat count
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            tick    <= '0;
            win_cnt <= '0;
        end else if (clr) begin
            tick    <= '0;
            win_cnt <= '0;
        end else if (terminal) begin
            tick    <= '0;
            win_cnt <= '0;
        end else begin
            tick    <= tick + 1'b1;
            win_cnt <= closing;
        end
    end

    // Circular history of closed window counts
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else if (terminal) begin
            hist[wr_ptr] <= closing;
        end
    end

    // Running sum, fill level and all outputs that update on window close
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            sum         <= '0;
            fill        <= '0;
            window_done <= 1'b0;
            bpm         <= '0;
            bpm_valid   <= 1'b0;
            no_signal   <= 1'b0;
            sat         <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            sum         <= '0;
            fill        <= '0;
            window_done <= 1'b0;
            bpm         <= '0;
            bpm_valid   <= 1'b0;
            no_signal   <= 1'b0;
            sat         <= 1'b0;
        end else begin
            window_done <= terminal;
            if (beat && cnt_full) begin
                sat <= 1'b1;
            end
            if (terminal) begin
                wr_ptr    <= wr_ptr + 1'b1;
                sum       <= new_sum;
                fill      <= fill_next;
                no_signal <= (closing == '0);
                if (fill_next == FILL_FULL) begin
                    bpm       <= bpm_next;
                    bpm_valid <= 1'b1;
                    if (bpm_clip) begin
                        sat <= 1'b1;
                    end
                end else begin
                    bpm       <= '0;
                    bpm_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bpm_window_averager.sv
// Directed bench for bpm_window_averager: a nominal instance (CW=8, BPM_W=10)
// and a narrow instance (CW=4, BPM_W=5) for clipping, sharing clock and rst.
module tb_bpm_window_averager;

    logic       sclk = 1'b0;
    logic       rst;
    logic       clr;
    logic       clr2;
    logic       pulse_in;
    logic       pulse2;

    logic       beat;
    logic       window_done;
    logic [9:0] bpm;
    logic       bpm_valid;
    logic       no_signal;
    logic       sat;

    logic       beat2;
    logic       done2;
    logic [4:0] bpm2;
    logic       valid2;
    logic       nosig2;
    logic       sat2;

    int tests    = 0;
    int failures = 0;

    bpm_window_averager #(
        .WIN_TICKS(100), .DEPTH(4), .SCALE(4), .MIN_GAP(5), .CW(8), .BPM_W(10)
    ) dut (
        .sclk(sclk), .rst(rst), .clr(clr), .pulse_in(pulse_in),
        .beat(beat), .window_done(window_done), .bpm(bpm),
        .bpm_valid(bpm_valid), .no_signal(no_signal), .sat(sat)
    );

    bpm_window_averager #(
        .WIN_TICKS(100), .DEPTH(4), .SCALE(4), .MIN_GAP(5), .CW(4), .BPM_W(5)
    ) dut_sat (
        .sclk(sclk), .rst(rst), .clr(clr2), .pulse_in(pulse2),
        .beat(beat2), .window_done(done2), .bpm(bpm2),
        .bpm_valid(valid2), .no_signal(nosig2), .sat(sat2)
    );

    always #5 sclk = ~sclk;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [99:0] train(input int n, input int period);
        logic [99:0] p;
        p = '0;
        for (int j = 0; j < 100; j++) begin
            if (j < n * period && (j % period) < 2) p[j] = 1'b1;
        end
        return p;
    endfunction

    // One full window from its tick-0 cycle; checks the window_done cycle
    task automatic apply_stimulus(input bit sel, input logic [99:0] pat, input int exp_beats,
                                  input int exp_bpm, input bit exp_valid, input bit exp_nosig,
                                  input bit exp_sat, input string tag);
        int beats;
        beats = 0;
        for (int j = 0; j < 100; j++) begin
            if (sel) pulse2 = pat[j];
            else     pulse_in = pat[j];
            if (j == 1) check_output({tag, ".done_low"}, 32'(sel ? done2 : window_done), 32'd0);
            beats += int'(sel ? beat2 : beat);
            step();
        end
        pulse_in = 1'b0;
        pulse2   = 1'b0;
        check_output({tag, ".beats"}, 32'(beats), 32'(exp_beats));
        check_output({tag, ".done"},  32'(sel ? done2  : window_done), 32'd1);
        check_output({tag, ".bpm"},   sel ? 32'(bpm2) : 32'(bpm), 32'(exp_bpm));
        check_output({tag, ".valid"}, 32'(sel ? valid2 : bpm_valid), 32'(exp_valid));
        check_output({tag, ".nosig"}, 32'(sel ? nosig2 : no_signal), 32'(exp_nosig));
        check_output({tag, ".sat"},   32'(sel ? sat2   : sat), 32'(exp_sat));
    endtask

    initial begin
        logic [99:0] pat;
        int          beats;

        rst      = 1'b1;
        clr      = 1'b0;
        clr2     = 1'b0;
        pulse_in = 1'b0;
        pulse2   = 1'b0;
        step();
        step();
        check_output("rst.done",  32'(window_done), 32'd0);
        check_output("rst.bpm",   32'(bpm),         32'd0);
        check_output("rst.valid", 32'(bpm_valid),   32'd0);
        check_output("rst.nosig", 32'(no_signal),   32'd0);
        check_output("rst.sat",   32'(sat),         32'd0);
        check_output("rst.beat",  32'(beat),        32'd0);
        check_output("rst.bpm2",  32'(bpm2),        32'd0);
        rst = 1'b0;

        // Steady rate, then a faster window
        apply_stimulus(0, train(10, 8), 10, 0,  0, 0, 0, "w1");
        apply_stimulus(0, train(10, 8), 10, 0,  0, 0, 0, "w2");
        apply_stimulus(0, train(10, 8), 10, 0,  0, 0, 0, "w3");
        apply_stimulus(0, train(10, 8), 10, 40, 1, 0, 0, "w4");
        apply_stimulus(0, train(20, 5), 20, 50, 1, 0, 0, "w5");

        // No signal and recovery; history is [20,10,10,10]
        apply_stimulus(0, '0,           0,  40, 1, 1, 0, "w6_nosig");
        apply_stimulus(0, train(10, 8), 10, 40, 1, 0, 0, "w7_recover");

        // Refractory: edges at steps 0, 3, 6 -> only 0 and 6 qualify
        pat = 100'h49;
        apply_stimulus(0, pat, 2, 32, 1, 0, 0, "w8_refr");

        // Beat landing on the terminal tick belongs to the closing window
        pat = '0;
        pat[96] = 1'b1;
        apply_stimulus(0, pat, 1, 13, 1, 0, 0, "w9_term");
        apply_stimulus(0, '0,  0, 13, 1, 1, 0, "w10_fresh");

        // Mid-window asynchronous reset with 3 beats counted
        pat   = train(3, 8);
        beats = 0;
        for (int j = 0; j < 40; j++) begin
            pulse_in = pat[j];
            beats += int'(beat);
            step();
        end
        pulse_in = 1'b0;
        check_output("mid.beats", 32'(beats), 32'd3);
        rst = 1'b1;
        #1;
        check_output("mid.bpm",   32'(bpm),       32'd0);
        check_output("mid.valid", 32'(bpm_valid), 32'd0);
        check_output("mid.nosig", 32'(no_signal), 32'd0);
        check_output("mid.done",  32'(window_done), 32'd0);
        step();
        rst = 1'b0;
        apply_stimulus(0, '0, 0, 0, 0, 1, 0, "post_rst");

        // Clipping on the narrow instance after a synchronous restart
        clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        check_output("clr2.bpm", 32'(bpm2), 32'd0);
        apply_stimulus(1, train(20, 5), 20, 0,  0, 0, 1, "s1");
        apply_stimulus(1, train(20, 5), 20, 0,  0, 0, 1, "s2");
        apply_stimulus(1, train(20, 5), 20, 0,  0, 0, 1, "s3");
        apply_stimulus(1, train(20, 5), 20, 31, 1, 0, 1, "s4");
        clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        check_output("clr.bpm",   32'(bpm2),   32'd0);
        check_output("clr.valid", 32'(valid2), 32'd0);
        check_output("clr.sat",   32'(sat2),   32'd0);
        check_output("clr.nosig", 32'(nosig2), 32'd0);
        check_output("clr.done",  32'(done2),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
